// File: rtl/alu_pkg.sv
// Shared constants, types and helpers for the mtm_Alu serial response path.
// crc3 and err_payload are also used by the bench scoreboard.
package alu_pkg;

   localparam int   FRAME_LEN = 11;
   localparam logic FT_DATA   = 1'b0;
   localparam logic FT_CTL    = 1'b1;

   // Bit positions inside the 3-bit err_flags field {ERR_DATA, ERR_CRC, ERR_OP}
   typedef enum logic [1:0] {
      ERR_OP   = 2'd0,
      ERR_CRC  = 2'd1,
      ERR_DATA = 2'd2
   } err_flag_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } ser_state_e;

   // x^3+x+1, initial value 0, message consumed MSB first
   function automatic logic [2:0] crc3(input logic [36:0] d);
      logic [2:0] c;
      logic       fb;
      c = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb = d[i] ^ c[2];
         c  = {c[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
      end
      return c;
   endfunction

   function automatic logic even_parity(input logic [6:0] d);
      return ^d;
   endfunction

   function automatic logic [7:0] err_payload(input logic [2:0] ef);
      return {1'b1, ef, ef, even_parity({1'b1, ef, ef})};
   endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Parallel response request bus feeding the serializer.
interface mtm_alu_serializer_if;
   logic        in_valid;
   logic        in_ready;
   logic        in_err;
   logic [31:0] in_c;
   logic [3:0]  in_flags;
   logic [2:0]  in_err_flags;

   modport master (
      output in_valid, in_err, in_c, in_flags, in_err_flags,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_err, in_c, in_flags, in_err_flags,
      output in_ready
   );
endinterface

// File: rtl/mtm_alu_frame_tx.sv
// Single-frame shifter: start, type, payload MSB first, stop. done marks the stop-bit
// cycle so the sequencer can reload without a gap.
module mtm_alu_frame_tx
   import alu_pkg::*;
#(
   parameter int FRAME_LEN = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       ftype,
   input  logic [7:0] payload,
   output logic       sout,
   output logic       done
);

   localparam int BC_W = $clog2(FRAME_LEN);

   logic                 busy;
   logic [BC_W-1:0]      bit_cnt;
   logic [FRAME_LEN-2:0] shreg;

   assign done = busy && (bit_cnt == BC_W'(FRAME_LEN - 1));

   // The start bit goes straight onto sout at load; shreg holds what follows it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
         sout    <= 1'b1;
      end else if (load) begin
         busy    <= 1'b1;
         bit_cnt <= '0;
         shreg   <= (FRAME_LEN-1)'({ftype, payload, 1'b1});
         sout    <= 1'b0;
      end else if (done) begin
         busy    <= 1'b0;
         bit_cnt <= '0;
         shreg   <= '0;
         sout    <= 1'b1;
      end else if (busy) begin
         bit_cnt <= bit_cnt + BC_W'(1);
         shreg   <= shreg << 1;
         sout    <= shreg[FRAME_LEN-2];
      end
   end

endmodule

// File: rtl/mtm_alu_serializer.sv
// Response-side serial transmitter: sequences data frames plus a CRC control frame,
// or a single error control frame, onto sout.
module mtm_alu_serializer
   import alu_pkg::*;
#(
   parameter int FRAME_LEN   = 11,
   parameter int DATA_FRAMES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mtm_alu_serializer_if.slave  rsp,
   output logic                 sout
);

   localparam int FC_W = $clog2(DATA_FRAMES + 1);

   ser_state_e      state, state_nxt;
   logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
   logic [31:0]     c_q;
   logic [31:0]     c_shift;
   logic [3:0]      flags_q;
   logic [2:0]      crc_q;
   logic            err_q;
   logic            accept;
   logic            load;
   logic            ftype;
   logic [7:0]      payload;
   logic            done;
   logic            last_frame;

   assign rsp.in_ready = (state == IDLE);
   assign accept       = (state == IDLE) && rsp.in_valid;

   always_comb begin
      state_nxt     = state;
      frame_cnt_nxt = frame_cnt;
      load          = 1'b0;
      ftype         = FT_DATA;
      payload       = '0;
      c_shift       = '0;
      last_frame    = err_q || (frame_cnt == FC_W'(DATA_FRAMES));
      case (state)
         IDLE: begin
            if (rsp.in_valid) begin
               state_nxt     = SEND;
               frame_cnt_nxt = '0;
               load          = 1'b1;
               if (rsp.in_err) begin
                  ftype   = FT_CTL;
                  payload = err_payload(rsp.in_err_flags);
               end else begin
                  payload = rsp.in_c[31:24];
               end
            end
         end
         SEND: begin
            if (done) begin
               if (last_frame) begin
                  state_nxt = IDLE;
               end else begin
                  frame_cnt_nxt = frame_cnt + FC_W'(1);
                  load          = 1'b1;
                  // Next frame is chosen from the captured word, never the live inputs
                  if (frame_cnt_nxt == FC_W'(DATA_FRAMES)) begin
                     ftype   = FT_CTL;
                     payload = {1'b0, flags_q, crc_q};
                  end else begin
                     c_shift = c_q << (8 * frame_cnt_nxt);
                     payload = c_shift[31:24];
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= frame_cnt_nxt;
         if (accept) begin
            err_q <= rsp.in_err;
         end
      end
   end

   // Payload capture; contents are don't-care until the next accept
   always_ff @(posedge clk) begin
      if (accept) begin
         c_q     <= rsp.in_c;
         flags_q <= rsp.in_flags;
         crc_q   <= crc3({rsp.in_c, 1'b0, rsp.in_flags});
      end
   end

   mtm_alu_frame_tx #(
      .FRAME_LEN (FRAME_LEN)
   ) u_frame_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .ftype   (ftype),
      .payload (payload),
      .sout    (sout),
      .done    (done)
   );

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Randomized bench for mtm_alu_serializer against a frame-list reference model
// and a bench-side deserializer.
module tb_mtm_alu_serializer;

   logic clk = 1'b0;
   logic rst_n;
   logic sout;
   int   n_vec = 0;
   int   n_err = 0;

   mtm_alu_serializer_if bus ();

   mtm_alu_serializer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rsp   (bus),
      .sout  (sout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // CRC as remainder of long division of msg*x^3 by 1011
   function automatic logic [2:0] ref_crc(input logic [36:0] msg);
      logic [39:0] r;
      r = {msg, 3'b000};
      for (int i = 39; i >= 3; i--)
         if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
      return r[2:0];
   endfunction

   function automatic logic [10:0] mk_frame(input logic t, input logic [7:0] p);
      return {1'b0, t, p, 1'b1};
   endfunction

   // Expected sout stream, first transmitted bit most significant
   function automatic logic [63:0] model_bits(input logic err, input logic [31:0] c,
                                              input logic [3:0] fl, input logic [2:0] ef);
      logic [63:0] v;
      logic [7:0]  p;
      v = '0;
      if (err) begin
         p = {1'b1, ef, ef, 1'b0};
         p[0] = ($countones(p) % 2) != 0;
         v = {53'd0, mk_frame(1'b1, p)};
      end else begin
         for (int k = 0; k < 4; k++) begin
            p = 8'((c >> (24 - 8 * k)) & 32'hFF);
            v = (v << 11) | {53'd0, mk_frame(1'b0, p)};
         end
         v = (v << 11) | {53'd0, mk_frame(1'b1, {1'b0, fl, ref_crc({c, 1'b0, fl})})};
      end
      return v;
   endfunction

   task automatic do_req(input logic err, input logic [31:0] c, input logic [3:0] fl,
                         input logic [2:0] ef);
      logic [63:0] got;
      logic [31:0] c_rx;
      logic [2:0]  crc_ref;
      int          len, low, w;
      len = err ? 11 : 55;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!bus.in_ready) begin
         check("ready_wait", 64'd0, 64'd1);
         return;
      end
      bus.in_valid = 1'b1;
      bus.in_err = err;
      bus.in_c = c;
      bus.in_flags = fl;
      bus.in_err_flags = ef;
      got = '0;
      low = 0;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         got = {got[62:0], sout};
         if (!bus.in_ready) low++;
         if (i == 0) begin
            bus.in_valid = 1'b0;
            bus.in_c = $urandom;
            bus.in_flags = 4'($urandom);
            bus.in_err_flags = 3'($urandom);
         end
      end
      @(negedge clk);
      check("idle_after", {62'd0, bus.in_ready, sout}, 64'd3);
      check("bits", got, model_bits(err, c, fl, ef));
      check("ready_low", 64'(low), 64'(len));
      if (!err) begin
         c_rx = {got[52:45], got[41:34], got[30:23], got[19:12]};
         crc_ref = ref_crc({c, 1'b0, fl});
         check("deser_c", {32'd0, c_rx}, {32'd0, c});
         check("crc_pkg", {61'd0, alu_pkg::crc3({c, 1'b0, fl})}, {61'd0, crc_ref});
         check("crc_rx", {61'd0, got[3:1]}, {61'd0, crc_ref});
      end
   endtask

   task automatic hold_test();
      logic        sh [0:299];
      int          acc_t [3];
      logic [31:0] acc_c [3];
      logic [3:0]  fl;
      logic [63:0] got;
      int          na;
      na = 0;
      fl = 4'b0110;
      bus.in_err = 1'b0;
      bus.in_flags = fl;
      bus.in_c = $urandom;
      for (int t = 0; t < 240; t++) begin
         @(negedge clk);
         sh[t] = sout;
         if (na == 3 && t > acc_t[2]) begin
            bus.in_valid = 1'b0;
         end else if (na < 3 && bus.in_ready) begin
            bus.in_valid = 1'b1;
            acc_t[na] = t;
            acc_c[na] = bus.in_c;
            na++;
         end else if (na > 0 && t == acc_t[na-1] + 20) begin
            bus.in_c = $urandom;
         end
      end
      bus.in_valid = 1'b0;
      check("hold_accepts", 64'(na), 64'd3);
      if (na == 3) begin
         for (int k = 0; k < 3; k++) begin
            if (k > 0) check("hold_spacing", 64'(acc_t[k] - acc_t[k-1]), 64'd56);
            got = '0;
            for (int i = 1; i <= 55; i++) got = {got[62:0], sh[acc_t[k] + i]};
            check("hold_bits", got, model_bits(1'b0, acc_c[k], fl, 3'd0));
         end
      end
   endtask

   initial begin
      int bad;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_err = 1'b0;
      bus.in_c = '0;
      bus.in_flags = '0;
      bus.in_err_flags = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {62'd0, bus.in_ready, sout}, 64'd3);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle", {62'd0, bus.in_ready, sout}, 64'd3);
      end

      do_req(1'b0, 32'h0000_0000, 4'b0010, 3'b000);
      do_req(1'b0, 32'hDEAD_BEEF, 4'b1001, 3'b000);
      check("err_payload_fn", {56'd0, alu_pkg::err_payload(3'b100)}, {56'd0, 8'b1100_1001});
      do_req(1'b1, 32'h1234_5678, 4'b1111, 3'b100);

      hold_test();

      // Abort during data frame 2
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_err = 1'b0;
      bus.in_c = 32'hA5A5_5A5A;
      bus.in_flags = 4'b0100;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (24) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_abort", {62'd0, bus.in_ready, sout}, 64'd3);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (!(bus.in_ready && sout)) bad++;
      end
      check("no_remainder", 64'(bad), 64'd0);
      do_req(1'b0, 32'hCAFE_F00D, 4'b0011, 3'b000);

      for (int i = 0; i < 10; i++)
         do_req(($urandom_range(0, 3) == 0), $urandom, 4'($urandom), 3'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Response-side serial transmitter for the mtm_Alu datapath. It accepts one parallel result per handshake and shifts it out on `sout` using the same 11-bit frame format that `sin` carries: either a 5-frame data response (result word plus control frame with CRC3) or a 1-frame error response. It is the counterpart of the ALU's input deserializer and drives `sout` directly.

## Interface
- `FRAME_LEN`, default 11: bits per frame (start, type, 8 payload, stop).
- `DATA_FRAMES`, default 4: data frames per result word.
- `clk`  in  1  posedge clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `in_valid`  in  1  response request.
- `in_ready`  out  1  block idle and able to accept.
- `in_err`  in  1  1 = send error response, 0 = send data response.
- `in_c`  in  32  result C.
- `in_flags`  in  4  {Carry, Overflow, Zero, Negative}.
- `in_err_flags`  in  3  {ERR_DATA, ERR_CRC, ERR_OP}.
- `sout`  out  1  serial output; idle level 1.

## Operation
- Frame format, bits in transmit order: start 0, type (0 data / 1 control), payload[7:0] MSB first, stop 1.
- Data response: 4 data frames carrying C[31:24], C[23:16], C[15:8], C[7:0], then a control frame with payload {1'b0, flags[3:0], crc[2:0]}.
- CRC3: polynomial x^3+x+1, initial value 0, computed over the 37-bit stream {C[31:0], 1'b0, flags[3:0]}, MSB first.
- Error response: one control frame with payload {1'b1, err_flags, err_flags, parity}, where parity makes the number of ones in the 8-bit payload even.
- Handshake: a request is accepted on a clock edge where `in_valid && in_ready`. The inputs are captured into internal registers at that edge and may change afterwards.
- FSM states:
  - IDLE: `in_ready`=1, `sout`=1. Moves to SEND on accept.
  - SEND: shifts the frame register one bit per cycle. A frame counter and a bit counter (0..10) advance each cycle.
  - After the stop bit of the final frame, returns to IDLE.
- Frames follow each other with no gap: the stop bit of one frame is immediately followed by the start bit of the next.
- `in_valid` while busy: ignored, since `in_ready`=0. The request is not queued.
- `in_err`=1 takes precedence: `in_c` and `in_flags` are not transmitted.

## Timing
- Reset: while `rst_n`=0 at a clock edge, the next state is IDLE, `sout`=1, `in_ready`=1, and counters and shift register are 0.
- Reset mid-frame aborts transmission. `sout` returns to 1 at the next edge and no remainder is sent.
- Latency: for an accept at edge N, `sout` carries the start bit of frame 0 from edge N until edge N+1.
- Duration: a data response occupies `sout` for 55 cycles; an error response for 11 cycles.
- `in_ready` is 0 from edge N through the final stop-bit cycle, and returns to 1 in the following cycle.
- Back-to-back data responses have a minimum accept-to-accept spacing of 56 cycles.
- `sout` is driven from a register; there is no combinational path from any input to `sout`.

## Structure
- Add to `alu_pkg`:
  - `FRAME_LEN`.
  - Type constants `FT_DATA`=0 and `FT_CTL`=1.
  - An enum for the error flags.
  - A `crc3` function, shared with the bench scoreboard.
  - A parity helper.
- One sub-module, `mtm_alu_frame_tx`: loads an 8-bit payload and a type bit, shifts out one 11-bit frame, and pulses `done` on the stop bit. The top level sequences frames and computes the CRC.

## Test plan
- Reset then idle for 20 cycles: `sout`=1 and `in_ready`=1 throughout.
- Data response with C=32'h0000_0000, flags=4'b0010:
  - 55 bits out, four all-zero data frames.
  - CRC3 equals `alu_pkg` `crc3`.
  - `in_ready` is low for exactly 55 cycles.
- Data response with C=32'hDEAD_BEEF, flags=4'b1001:
  - Frames carry payloads DE, AD, BE, EF.
  - Control payload is {0, 1001, crc3}.
  - The bench deserializer reproduces C exactly.
- Error response with `in_err`=1, `in_err_flags`=3'b100: a single frame 0 1 1 100100 1 1 (payload 8'b1100_1001), 11 cycles, then idle.
- `in_valid` held high continuously for 3 requests: accepts are spaced exactly 56 cycles apart, and mid-response changes to `in_c` do not alter the frames being sent.
- `rst_n` pulled low for 1 cycle during data frame 2: `sout`=1 at the next edge, `in_ready`=1, and a subsequent request transmits cleanly.
